// File: rtl/upload_packet_scheduler.sv
// Packet-aware round-robin scheduler merging NUM_SOURCES byte streams onto one
// upload path, with a registered valid/ready output stage and a stall watchdog.
module upload_packet_scheduler #(
    parameter int NUM_SOURCES    = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W         = $clog2(NUM_SOURCES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SOURCES-1:0]     src_valid,
    input  logic [NUM_SOURCES*8-1:0]   src_data,
    input  logic [NUM_SOURCES*8-1:0]   src_source,
    input  logic [NUM_SOURCES-1:0]     src_last,
    output logic [NUM_SOURCES-1:0]     src_ready,
    input  logic [NUM_SOURCES-1:0]     src_enable,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    output logic [7:0]                 out_source,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [IDX_W-1:0]           grant_idx,
    output logic                       busy,
    output logic                       err_timeout,
    output logic [IDX_W-1:0]           err_source
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] err_source_q, err_source_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic [7:0]       out_source_q, out_source_d;
    logic             out_last_q, out_last_d;
    logic             err_timeout_q, err_timeout_d;

    logic [7:0] data_arr [NUM_SOURCES];
    logic [7:0] tag_arr  [NUM_SOURCES];

    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_unpack
        assign data_arr[gi] = src_data[gi*8 +: 8];
        assign tag_arr[gi]  = src_source[gi*8 +: 8];
    end

    logic [NUM_SOURCES-1:0] req;
    logic                   found;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       next_ptr;
    int                     arb_idx;

    assign req = src_valid & src_enable;

    // First requester at or after rr_ptr, wrapping modulo NUM_SOURCES.
    always_comb begin
        found   = 1'b0;
        winner  = rr_ptr_q;
        arb_idx = 0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            arb_idx = (int'(rr_ptr_q) + k) % NUM_SOURCES;
            if (!found && req[arb_idx]) begin
                found  = 1'b1;
                winner = IDX_W'(arb_idx);
            end
        end
        next_ptr = IDX_W'((int'(winner) + 1) % NUM_SOURCES);
    end

    logic g_valid;
    logic slot_free;
    logic accept;

    assign g_valid   = src_valid[grant_idx_q];
    assign slot_free = !out_valid_q || out_ready;
    assign accept    = (state_q == GRANT) && g_valid && slot_free;

    always_comb begin
        src_ready = '0;
        if (state_q == GRANT) begin
            src_ready[grant_idx_q] = slot_free;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        rr_ptr_d      = rr_ptr_q;
        err_source_d  = err_source_q;
        wd_d          = wd_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_source_d  = out_source_q;
        out_last_d    = out_last_q;
        err_timeout_d = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_idx_d = winner;
                    rr_ptr_d    = next_ptr;
                    state_d     = GRANT;
                    wd_d        = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = data_arr[grant_idx_q];
                    out_source_d = tag_arr[grant_idx_q];
                    out_last_d   = src_last[grant_idx_q];
                    wd_d         = '0;
                    if (src_last[grant_idx_q]) begin
                        state_d = IDLE;
                    end
                end else if (!g_valid) begin
                    // Abort drops the grant only; a byte already in the output register still drains.
                    if (wd_q >= WD_W'(TIMEOUT_CYCLES - 1)) begin
                        err_timeout_d = 1'b1;
                        err_source_d  = grant_idx_q;
                        state_d       = IDLE;
                    end else if (wd_q != '1) begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_idx_q   <= '0;
            rr_ptr_q      <= '0;
            err_source_q  <= '0;
            wd_q          <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_source_q  <= '0;
            out_last_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            rr_ptr_q      <= rr_ptr_d;
            err_source_q  <= err_source_d;
            wd_q          <= wd_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_source_q  <= out_source_d;
            out_last_q    <= out_last_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_source  = out_source_q;
    assign out_last    = out_last_q;
    assign grant_idx   = grant_idx_q;
    assign busy        = (state_q == GRANT);
    assign err_timeout = err_timeout_q;
    assign err_source  = err_source_q;

endmodule

// File: tb/tb_upload_packet_scheduler.sv
// Scoreboard bench: packets are queued per source, a packet-level round-robin
// model orders them into the expected byte stream, and a monitor checks the output.
module tb_upload_packet_scheduler;
    localparam int NS = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NS-1:0]   src_valid;
    logic [NS*8-1:0] src_data;
    logic [NS*8-1:0] src_source;
    logic [NS-1:0]   src_last;
    logic [NS-1:0]   src_ready;
    logic [NS-1:0]   src_enable;
    logic            out_valid;
    logic [7:0]      out_data;
    logic [7:0]      out_source;
    logic            out_last;
    logic            out_ready;
    logic [1:0]      grant_idx;
    logic            busy;
    logic            err_timeout;
    logic [1:0]      err_source;

    always #5 clk = ~clk;

    upload_packet_scheduler #(.NUM_SOURCES(NS), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid(src_valid), .src_data(src_data), .src_source(src_source),
        .src_last(src_last), .src_ready(src_ready), .src_enable(src_enable),
        .out_valid(out_valid), .out_data(out_data), .out_source(out_source),
        .out_last(out_last), .out_ready(out_ready), .grant_idx(grant_idx),
        .busy(busy), .err_timeout(err_timeout), .err_source(err_source)
    );

    int checks = 0;
    int errors = 0;
    logic [8:0]  sq   [NS][$];   // bytes still to be offered by each source {last,data}
    logic [8:0]  pend [NS][$];   // packets generated but not yet ordered by the model
    logic [16:0] exp_q [$];      // expected output stream {last,tag,data}
    logic [7:0]  tag [NS] = '{8'h01, 8'h42, 8'h83, 8'hC4};
    bit          mid [NS];
    int          gap [NS];
    logic [NS-1:0] en = 4'hF;
    logic [NS-1:0] acc;
    logic [3:0]  pat = 4'b1001;
    int          rdy_mode = 0;
    int          cyc = 0;
    int          model_rr = 0;
    int          timeouts = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic gen_pkt(input int s, input int len, input bit aborted);
        logic l;
        logic [7:0] d;
        for (int b = 0; b < len; b++) begin
            l = (b == len - 1) && !aborted;
            d = 8'($urandom);
            pend[s].push_back({l, d});
        end
    endtask

    // Whole packets go out in round-robin order over enabled sources with work pending.
    task automatic plan(input logic [NS-1:0] m);
        int w;
        logic [8:0] b;
        while (1) begin
            w = -1;
            for (int k = 0; k < NS; k++) begin
                int idx;
                idx = (model_rr + k) % NS;
                if (w < 0 && m[idx] && pend[idx].size() > 0) w = idx;
            end
            if (w < 0) break;
            do begin
                b = pend[w].pop_front();
                sq[w].push_back(b);
                exp_q.push_back({b[8], tag[w], b[7:0]});
            end while (!b[8] && pend[w].size() > 0);
            model_rr = (w + 1) % NS;
        end
    endtask

    task automatic tick();
        logic [8:0] b;
        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
            src_valid[i] = (sq[i].size() > 0) && (gap[i] == 0);
            src_data[i*8 +: 8] = src_valid[i] ? sq[i][0][7:0] : 8'h00;
            src_last[i] = src_valid[i] ? sq[i][0][8] : 1'b0;
            src_source[i*8 +: 8] = tag[i];
        end
        src_enable = en;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = pat[2'(cyc % 4)];
        endcase
        cyc++;
        #4;
        for (int i = 0; i < NS; i++) begin
            acc[i] = src_valid[i] && src_ready[i];
            if (acc[i]) begin
                b = sq[i].pop_front();
                mid[i] = !b[8];
                if (mid[i] && sq[i].size() > 0 && $urandom_range(0, 3) == 0) gap[i] = $urandom_range(1, 3);
            end else if (gap[i] > 0) begin
                gap[i]--;
            end
        end
    endtask

    function automatic bit pending(input logic [NS-1:0] m);
        for (int i = 0; i < NS; i++) if (m[i] && sq[i].size() > 0) return 1'b1;
        return exp_q.size() > 0;
    endfunction

    task automatic drain(input logic [NS-1:0] m, input string name);
        int n;
        n = 0;
        while (pending(m) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            errors++;
            checks++;
            $display("FAIL drain_%s actual=%0d_bytes_left required=0", name, exp_q.size());
        end
        tick();
        tick();
    endtask

    task automatic wait_acc(input int s, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc[s] && n < 20);
        check_eq(name, 32'(acc[s]), 32'd1);
    endtask

    // Monitor: pops one expected byte per output transfer, checks hold-while-stalled.
    initial begin
        bit stalled_prev;
        logic [16:0] prev;
        logic [16:0] e;
        stalled_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                stalled_prev = 1'b0;
                continue;
            end
            if (err_timeout) timeouts++;
            if (stalled_prev) begin
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_data", 32'({out_last, out_source, out_data}), 32'(prev));
            end
            if (out_valid && !out_ready) check_eq("ready_when_stalled", 32'(src_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", 32'({out_last, out_source, out_data}), 32'h1ffff);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("beat", 32'({out_last, out_source, out_data}), 32'(e));
                    $display("beat src_tag=%02h data=%02h last=%0d", out_source, out_data, out_last);
                end
            end
            stalled_prev = out_valid && !out_ready;
            prev = {out_last, out_source, out_data};
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int t;
        int s1_left;
        src_valid = '0; src_data = '0; src_source = '0; src_last = '0;
        src_enable = '0; out_ready = 1'b0; acc = '0;
        for (int i = 0; i < NS; i++) begin mid[i] = 0; gap[i] = 0; end

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_src_ready", 32'(src_ready), 32'd0);
        rst_n = 1'b1;
        tick(); tick();
        check_eq("idle_outputs", 32'({out_valid, busy, err_timeout, grant_idx, err_source, out_data}), 32'd0);

        // Single packet with latency checks
        pend[0].push_back({1'b0, 8'h11});
        pend[0].push_back({1'b0, 8'h22});
        pend[0].push_back({1'b1, 8'h33});
        plan(4'hF);
        tick();
        check_eq("lat_edge_k", 32'(out_valid), 32'd0);
        tick();
        check_eq("lat_edge_k1", 32'(out_valid), 32'd0);
        check_eq("grant_busy", 32'(busy), 32'd1);
        check_eq("grant_idx0", 32'(grant_idx), 32'd0);
        check_eq("src_ready0", 32'(src_ready), 32'd1);
        tick();
        check_eq("lat_edge_k2", 32'({out_valid, out_data}), 32'h111);
        drain(4'hF, "single");

        // Fairness with continuous 2-byte packets
        for (int i = 0; i < NS; i++) for (int p = 0; p < 3; p++) gen_pkt(i, 2, 1'b0);
        plan(4'hF);
        drain(4'hF, "fair");

        // Randomised traffic and random backpressure
        rdy_mode = 1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NS; i++) begin
                int np;
                np = $urandom_range(0, 4);
                for (int p = 0; p < np; p++) gen_pkt(i, $urandom_range(1, 6), 1'b0);
            end
            plan(4'hF);
            drain(4'hF, "random");
        end

        // Backpressure pattern 1,0,0,1 on a 5-byte packet, then mixed traffic
        rdy_mode = 2;
        gen_pkt(2, 5, 1'b0);
        plan(4'hF);
        drain(4'hF, "bp_single");
        for (int i = 0; i < NS; i++) gen_pkt(i, $urandom_range(2, 5), 1'b0);
        plan(4'hF);
        drain(4'hF, "bp_multi");

        // Mask: source 1 requests but is never granted
        rdy_mode = 1;
        en = 4'b1101;
        for (int i = 0; i < NS; i++) for (int p = 0; p < 2; p++) gen_pkt(i, $urandom_range(1, 4), 1'b0);
        plan(4'b1101);
        while (pend[1].size() > 0) sq[1].push_back(pend[1].pop_front());
        s1_left = sq[1].size();
        drain(4'b1101, "mask");
        check_eq("masked_src1_untouched", 32'(sq[1].size()), 32'(s1_left));
        sq[1].delete();
        en = 4'hF;
        tick();

        // Clearing enable mid-packet lets the packet finish
        rdy_mode = 0;
        gen_pkt(0, 5, 1'b0);
        plan(4'hF);
        wait_acc(0, "en_first_byte");
        en = 4'b1110;
        drain(4'hF, "en_clear");
        en = 4'hF;

        // Watchdog: one non-last byte then silence
        gen_pkt(3, 1, 1'b1);
        plan(4'hF);
        wait_acc(3, "wd_first_byte");
        t = 0;
        do begin
            tick();
            t++;
        end while (!err_timeout && t < 40);
        // Pulse is registered 16 edges after the accepting edge, seen at the 17th sample.
        check_eq("wd_delay", 32'(t), 32'd17);
        check_eq("wd_err_source", 32'(err_source), 32'd3);
        check_eq("wd_busy_low", 32'(busy), 32'd0);
        tick();
        check_eq("wd_pulse_width", 32'(err_timeout), 32'd0);
        check_eq("wd_err_source_held", 32'(err_source), 32'd3);
        gen_pkt(1, 2, 1'b0);
        gen_pkt(0, 2, 1'b0);
        plan(4'hF);
        tick();
        tick();
        check_eq("wd_next_grant", 32'({busy, grant_idx}), 32'h4);
        drain(4'hF, "after_wd");

        // Asynchronous reset mid-packet
        gen_pkt(1, 8, 1'b0);
        plan(4'hF);
        t = 0;
        while (exp_q.size() > 5 && t < 40) begin
            tick();
            t++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_outputs", 32'({out_valid, out_last, busy, err_timeout, grant_idx, err_source}), 32'd0);
        check_eq("arst_data", 32'({out_data, out_source}), 32'd0);
        check_eq("arst_src_ready", 32'(src_ready), 32'd0);
        for (int i = 0; i < NS; i++) begin
            sq[i].delete(); pend[i].delete(); mid[i] = 0; gap[i] = 0;
        end
        exp_q.delete();
        model_rr = 0;
        src_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gen_pkt(3, 3, 1'b0);
        gen_pkt(2, 2, 1'b0);
        gen_pkt(1, 4, 1'b0);
        plan(4'hF);
        tick();
        tick();
        check_eq("post_rst_grant", 32'({busy, grant_idx}), 32'h5);
        drain(4'hF, "post_reset");

        check_eq("timeout_count", 32'(timeouts), 32'd1);
        check_eq("stream_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/upload_packet_scheduler.md
Name: upload_packet_scheduler

Overview:
- Packet-aware round-robin scheduler sharing the single processor upload path between NUM_SOURCES byte-stream producers.
- Grants one source per packet and holds the grant until that source's last byte, so packets are never interleaved.
- Registered output stage with valid/ready backpressure.
- Stall watchdog releases a hung grant and reports the offending source.

Parameters:
- NUM_SOURCES, 4, number of requesting sources (2..8).
- TIMEOUT_CYCLES, 1024, consecutive mid-packet cycles with src_valid low before the grant is aborted.
- IDX_W, $clog2(NUM_SOURCES), width of the grant index (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- src_valid  in  NUM_SOURCES  per-source byte valid.
- src_data  in  NUM_SOURCES*8  per-source byte; source i occupies bits [i*8+:8].
- src_source  in  NUM_SOURCES*8  per-source 8-bit source ID tag.
- src_last  in  NUM_SOURCES  marks the final byte of a packet.
- src_ready  out  NUM_SOURCES  per-source accept.
- src_enable  in  NUM_SOURCES  arbitration mask; 0 means never granted.
- out_valid  out  1  merged byte valid (registered).
- out_data  out  8  merged byte.
- out_source  out  8  source ID tag of out_data.
- out_last  out  1  last byte of packet.
- out_ready  in  1  downstream accept.
- grant_idx  out  IDX_W  currently or last granted source.
- busy  out  1  high while in GRANT.
- err_timeout  out  1  single-cycle abort pulse.
- err_source  out  IDX_W  source aborted by the watchdog; held until the next abort.

Behaviour:
- Reset values:
  - All outputs 0.
  - state=IDLE, rr_ptr=0, watchdog=0, output register empty.
  - Asynchronous reset mid-packet discards the partial packet and the output register contents.
- States:
  - IDLE: arbitrate.
  - GRANT: stream the granted packet.
- IDLE arbitration:
  - Requesters are sources with src_valid[i] && src_enable[i].
  - Search starts at rr_ptr and wraps modulo NUM_SOURCES; the first requester found wins.
  - On a win: grant_idx<=winner, rr_ptr<=(winner+1) mod NUM_SOURCES, state<=GRANT, watchdog<=0.
  - No requester: remain in IDLE, no pointer change.
  - src_ready is all-zero in IDLE.
- GRANT:
  - src_ready[g] = (!out_valid || out_ready), all other src_ready bits 0. g = grant_idx.
  - Beat accepted on an edge where src_valid[g] && src_ready[g]:
    - out_data/out_source/out_last load from source g.
    - out_valid<=1.
    - watchdog<=0.
  - Accepted beat with src_last[g]=1: state<=IDLE.
- Arbitration bubble: a source cannot be re-granted on the edge its last byte is accepted. There is a minimum of 1 IDLE cycle between packets.
- Latency:
  - Request seen at edge k gives the grant at edge k.
  - src_ready is high during cycle k+1.
  - First byte accepted at edge k+1 appears on out at cycle k+2.
- Output register:
  - On an edge with out_valid && out_ready and no new beat: out_valid<=0.
  - Simultaneous drain and load is a valid transfer, so full throughput is 1 byte/cycle.
  - out_data/out_source/out_last hold stable while out_valid && !out_ready.
- Enable mask:
  - Deasserting src_enable[g] during GRANT does not abort. The packet completes.
  - The mask only affects new grants.
- Watchdog:
  - In GRANT, the counter increments each cycle src_valid[g]=0. Cycles stalled by out_ready=0 do not count, because src_valid is high.
  - On the cycle it reaches TIMEOUT_CYCLES-1 with src_valid[g] still 0:
    - err_timeout pulses 1 cycle.
    - err_source<=g.
    - state<=IDLE.
  - No out_last is synthesised. rr_ptr already points past g.
  - A byte already in the output register still drains normally.
- Counter width: $clog2(TIMEOUT_CYCLES)+1 bits, saturating, no wrap.
- busy = (state==GRANT).

Test Plan:
- Single packet: src0 sends 0x11,0x22,0x33 (last on 0x33), tag 0x01, out_ready=1 -> out shows 11,22,33 on consecutive cycles; out_last only with 33; out_source=0x01; first out_valid 2 cycles after src_valid rises.
- Fairness: all 4 sources hold 2-byte packets continuously -> grant order 0,1,2,3,0,1…; no interleaving; one bubble between packets.
- Backpressure: out_ready toggles 1,0,0,1 during a 5-byte packet from src2 -> no byte lost or duplicated; out_* stable while stalled; src_ready[2] low whenever out_valid && !out_ready.
- Mask: src_enable=4'b1101 with all sources requesting -> source 1 never granted; clearing src_enable[0] mid-packet lets that packet finish.
- Watchdog: TIMEOUT_CYCLES=16; src3 sends 1 byte (not last) then drops valid -> err_timeout pulses once 16 cycles later; err_source=3; busy falls; src0 is granted next.
- Reset: assert rst_n low mid-packet -> all outputs 0 immediately; after release, src1 packet completes normally with a rr_ptr=0 start.
